// File: rtl/seg7_scan_display.sv
// 8-digit multiplexed hex display fed by the CPU display value or one of three perf counters.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero nibble.
module seg7_scan_display #(
   parameter int SCAN_DIV       = 100000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] Leddata,
   input  logic [31:0] Count_cycle,
   input  logic [31:0] Count_branch,
   input  logic [31:0] Count_jmp,
   input  logic [1:0]  sel,
   input  logic        freeze,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [7:0]  an
);

   localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
   localparam logic [7:0] AN_OFF  = AN_ACTIVE_LOW ? 8'hFF : 8'h00;

   logic [DIV_W-1:0] div_cnt;
   logic [2:0]       dig;
   logic [31:0]      shadow;
   logic [1:0]       sel_s;
   logic             prime;

   logic             tick;
   logic             load;
   logic [31:0]      src;
   logic             blank;
   logic [3:0]       nib;
   logic [7:0]       an_nxt;
   logic [6:0]       seg_nxt;
   logic             dp_nxt;

   function automatic logic [6:0] hex_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   always_comb begin
      case (sel)
         2'd0:    src = Leddata;
         2'd1:    src = Count_cycle;
         2'd2:    src = Count_branch;
         default: src = Count_jmp;
      endcase
   end

   assign tick = (div_cnt == DIV_LAST);
   // The snapshot is refreshed only once after reset and at unfrozen frame boundaries.
   assign load = prime || (tick && (dig == 3'd7) && !freeze);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         div_cnt <= '0;
         dig     <= '0;
         shadow  <= '0;
         sel_s   <= '0;
         prime   <= 1'b1;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) dig <= dig + 3'd1;
         if (load) begin
            shadow <= src;
            sel_s  <= sel;
         end
         prime <= 1'b0;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [2:0] top_nz;

   always_comb begin
      top_nz = '0;
      for (int i = 1; i < 8; i++) begin
         if (shadow[4*i +: 4] != 4'h0) top_nz = 3'(i);
      end
   end

   assign blank = (dig > top_nz);
`else
   assign blank = 1'b0;
`endif

   assign nib = shadow[{dig, 2'b00} +: 4];

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      an_nxt  = AN_OFF;
      seg_nxt = SEG_OFF;
      dp_nxt  = DP_OFF;
      if (!prime && !blank) begin
         an_nxt  = AN_ACTIVE_LOW ? ~(8'b1 << dig) : (8'b1 << dig);
         seg_nxt = SEG_ACTIVE_LOW ? ~hex_decode(nib) : hex_decode(nib);
         dp_nxt  = (dig == {1'b0, sel_s}) ? ~DP_OFF : DP_OFF;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         an  <= AN_OFF;
         seg <= SEG_OFF;
         dp  <= DP_OFF;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
         dp  <= dp_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display (SCAN_DIV=4, active-low segments and anodes).
// A behavioural model queues the expected outputs every clock; directed checks cover the key scenarios.
module tb_seg7_scan_display;

   localparam int SCAN_DIV = 4;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] Leddata = '0;
   logic [31:0] Count_cycle = '0;
   logic [31:0] Count_branch = '0;
   logic [31:0] Count_jmp = '0;
   logic [1:0]  sel = '0;
   logic        freeze = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [7:0]  an;

   int total = 0;
   int bad = 0;

   exp_t sb_q[$];

   int          m_div;
   int          m_dig;
   logic [31:0] m_shadow;
   logic [1:0]  m_sel_s;
   logic        m_prime;

   seg7_scan_display #(
      .SCAN_DIV(SCAN_DIV),
      .SEG_ACTIVE_LOW(1'b1),
      .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk),
      .clr(clr),
      .Leddata(Leddata),
      .Count_cycle(Count_cycle),
      .Count_branch(Count_branch),
      .Count_jmp(Count_jmp),
      .sel(sel),
      .freeze(freeze),
      .seg(seg),
      .dp(dp),
      .an(an)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h required=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model_out(input int d, input logic [31:0] sh, input logic [1:0] ss,
                                      input logic pr);
      logic [6:0] tbl [16];
      exp_t       e;
      int         top;
      logic [3:0] n;
      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};
      top = 7;
`ifdef LEADING_ZERO_BLANK_EN
      top = 0;
      for (int i = 0; i < 8; i++) if (((sh >> (4 * i)) & 32'hF) != 0) top = i;
`endif
      if (!pr && d <= top) begin
         n     = 4'((sh >> (4 * d)) & 32'hF);
         e.an  = ~(8'd1 << d);
         e.seg = ~tbl[n];
         e.dp  = (d == int'(ss)) ? 1'b0 : 1'b1;
      end
      return e;
   endfunction

   function automatic logic [31:0] model_src(input logic [1:0] s);
      case (s)
         2'd0:    return Leddata;
         2'd1:    return Count_cycle;
         2'd2:    return Count_branch;
         default: return Count_jmp;
      endcase
   endfunction

   // Reference model: one expected output set is queued per rising edge.
   always @(posedge clk or posedge clr) begin
      if (clr) begin
         m_div    <= 0;
         m_dig    <= 0;
         m_shadow <= '0;
         m_sel_s  <= '0;
         m_prime  <= 1'b1;
         sb_q.delete();
      end else begin
         sb_q.push_back(model_out(m_dig, m_shadow, m_sel_s, m_prime));
         m_div <= (m_div == SCAN_DIV - 1) ? 0 : m_div + 1;
         if (m_div == SCAN_DIV - 1) m_dig <= (m_dig + 1) % 8;
         if (m_prime || (m_div == SCAN_DIV - 1 && m_dig == 7 && !freeze)) begin
            m_shadow <= model_src(sel);
            m_sel_s  <= sel;
         end
         m_prime <= 1'b0;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (clr) begin
         check("rst_an", an, 8'hFF);
         check("rst_seg", seg, 7'h7F);
         check("rst_dp", dp, 1'b1);
      end else if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("sb_an", an, e.an);
         check("sb_seg", seg, e.seg);
         check("sb_dp", dp, e.dp);
      end
   end

   task automatic wait_an(input int d);
      int         n;
      logic [7:0] want;
      n    = 0;
      want = ~(8'd1 << d);
      do begin
         @(negedge clk);
         n++;
      end while (an !== want && n < 200);
      if (an !== want) check("wait_an_timeout", an, want);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int ff_cnt;

      // 1. reset and first display
      #1 clr = 1'b1;
      repeat (3) @(negedge clk);
      check("t1_rst_an", an, 8'hFF);
      check("t1_rst_seg", seg, 7'h7F);
      check("t1_rst_dp", dp, 1'b1);
      #1 clr = 1'b0;
      @(negedge clk);
      check("t1_edge1_an", an, 8'hFF);
      @(negedge clk);
      check("t1_edge2_an", an, 8'hFE);
      check("t1_edge2_seg", seg, 7'h40);
      check("t1_edge2_dp", dp, 1'b0);

      // 2. scan of 1234ABCD
      Leddata = 32'h1234ABCD;
      wait_an(7);
      wait_an(0);
      check("t2_d0_seg", seg, 7'h21);
      wait_an(4);
      check("t2_d4_seg", seg, 7'h19);
      wait_an(7);
      check("t2_d7_seg", seg, 7'h79);

      // 3. mid-frame source change waits for the boundary
      wait_an(3);
      Leddata = 32'hFFFFFFFF;
      wait_an(5);
      check("t3_d5_old_seg", seg, 7'h30);
      wait_an(0);
      check("t3_d0_new_seg", seg, 7'h0E);

      // 5. clr pulse while digit 5 is shown
      wait_an(5);
      #1 clr = 1'b1;
      #1;
      check("t5_async_an", an, 8'hFF);
      check("t5_async_seg", seg, 7'h7F);
      check("t5_async_dp", dp, 1'b1);
      @(negedge clk);
      #1 clr = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (an === 8'hFF && n < 20);
      check("t5_first_digit_an", an, 8'hFE);

      // 4. freeze holds the snapshot, then a source switch
      wait_an(3);
      freeze  = 1'b1;
      Leddata = 32'h11111111;
      wait_an(0);
      check("t4_frozen_seg", seg, 7'h0E);
      wait_an(3);
      freeze      = 1'b0;
      sel         = 2'd1;
      Count_cycle = 32'd5;
      wait_an(0);
      check("t4_cycle_seg", seg, 7'h12);
      check("t4_d0_dp", dp, 1'b1);
`ifndef LEADING_ZERO_BLANK_EN
      wait_an(1);
      check("t4_d1_dp", dp, 1'b0);
      check("t4_d1_seg", seg, 7'h40);
      wait_an(2);
      check("t4_d2_dp", dp, 1'b1);
`endif

`ifdef LEADING_ZERO_BLANK_EN
      // 6. leading-zero blanking
      sel     = 2'd0;
      Leddata = 32'h00000042;
      repeat (70) @(negedge clk);
      ff_cnt = 0;
      for (int i = 0; i < 8 * SCAN_DIV; i++) begin
         @(negedge clk);
         check("t6_42_an_range", (an == 8'hFE || an == 8'hFD || an == 8'hFF), 1'b1);
         if (an == 8'hFF) ff_cnt++;
      end
      check("t6_42_blank_slots", ff_cnt, 6 * SCAN_DIV);
      Leddata = 32'h0;
      repeat (70) @(negedge clk);
      ff_cnt = 0;
      for (int i = 0; i < 8 * SCAN_DIV; i++) begin
         @(negedge clk);
         check("t6_zero_an_range", (an == 8'hFE || an == 8'hFF), 1'b1);
         if (an == 8'hFF) ff_cnt++;
         else check("t6_zero_seg", seg, 7'h40);
      end
      check("t6_zero_blank_slots", ff_cnt, 7 * SCAN_DIV);
`endif

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
